// File: rtl/sram_1rw_param_init.sv
// -----------------------------------------------------------------------------
// sram_1rw_param_init
//
// Single-port (one read-or-write per cycle) SRAM model with a self-initialising
// sweep. After reset the array is filled with INIT_VALUE, one word per cycle,
// starting at address 0. Requests are ignored until the sweep finishes and
// ready0 rises. Writes are granule-masked; reads return data on a registered
// output after READ_LATENCY cycles, flagged by a one-cycle dout_valid0 pulse.
//
// Parameters
//   DATA_WIDTH   : word width in bits
//   ADDR_WIDTH   : address width; the array holds 2**ADDR_WIDTH words
//   WSIZE        : write-mask granule in bits (DATA_WIDTH must be a multiple)
//   READ_LATENCY : 1 or 2 cycles from read accept to dout_valid0
//   INIT_VALUE   : word written to every location by the init sweep
//
// Ports
//   clk0        : clock, all state changes on its rising edge
//   rst_aL      : asynchronous active-low reset
//   csb0        : active-low chip select
//   web0        : active-low write enable (1 = read)
//   wmask0      : per-granule write enable, bit i covers din0[i*WSIZE +: WSIZE]
//   addr0       : word address
//   din0        : write data
//   dout0       : registered read data, held between reads
//   dout_valid0 : one-cycle pulse marking fresh dout0
//   ready0      : high once the init sweep has completed
// -----------------------------------------------------------------------------
module sram_1rw_param_init #(
    parameter int unsigned              DATA_WIDTH   = 128,
    parameter int unsigned              ADDR_WIDTH   = 6,
    parameter int unsigned              WSIZE        = 8,
    parameter int unsigned              READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0]    INIT_VALUE   = '0
) (
    input  logic                        clk0,
    input  logic                        rst_aL,
    input  logic                        csb0,
    input  logic                        web0,
    input  logic [DATA_WIDTH/WSIZE-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]       addr0,
    input  logic [DATA_WIDTH-1:0]       din0,
    output logic [DATA_WIDTH-1:0]       dout0,
    output logic                        dout_valid0,
    output logic                        ready0
);

    localparam int unsigned NUM_WMASKS = DATA_WIDTH / WSIZE;
    localparam int unsigned RAM_DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (WSIZE == 0) begin : gen_bad_wsize_zero
        $error("sram_1rw_param_init: WSIZE must be non-zero");
    end

    if ((WSIZE != 0) && ((DATA_WIDTH % WSIZE) != 0)) begin : gen_bad_wsize
        $error("sram_1rw_param_init: DATA_WIDTH (%0d) not a multiple of WSIZE (%0d)",
               DATA_WIDTH, WSIZE);
    end

    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : gen_bad_latency
        $error("sram_1rw_param_init: READ_LATENCY (%0d) must be 1 or 2", READ_LATENCY);
    end

    // -------------------------------------------------------------------------
    // Init / ready FSM
    // -------------------------------------------------------------------------
    typedef enum logic {
        StInit,
        StReady
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    init_we;

    always_ff @(posedge clk0 or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        unique case (state_q)
            StInit: begin
                init_we = 1'b1;
                // The last word is written on the same edge that leaves INIT,
                // so the counter parks at LAST_ADDR instead of wrapping.
                if (cnt_q == LAST_ADDR) begin
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    // ready0 comes straight from the state register, so it has no path from inputs.
    assign ready0 = (state_q == StReady);

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic accept;
    logic wr_en;
    logic rd_en;

    assign accept = ready0 && !csb0;
    assign wr_en  = accept && !web0;
    assign rd_en  = accept && web0;

    // -------------------------------------------------------------------------
    // Storage array. Not reset: the init sweep provides its contents.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    always_ff @(posedge clk0) begin
        if (init_we) begin
            mem_q[cnt_q] <= INIT_VALUE;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0[i]) begin
                    mem_q[addr0][i*WSIZE +: WSIZE] <= din0[i*WSIZE +: WSIZE];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] rd_word;
    assign rd_word = mem_q[addr0];

    // -------------------------------------------------------------------------
    // Read pipeline. rd_vld_last/rd_data_last feed the output register; with
    // READ_LATENCY = 2 an extra stage sits in front of it.
    // -------------------------------------------------------------------------
    logic                  rd_vld_last;
    logic [DATA_WIDTH-1:0] rd_data_last;

    if (READ_LATENCY == 2) begin : gen_lat2
        logic                  pipe_vld_q;
        logic [DATA_WIDTH-1:0] pipe_data_q;

        always_ff @(posedge clk0 or negedge rst_aL) begin
            if (!rst_aL) begin
                pipe_vld_q  <= 1'b0;
                pipe_data_q <= '0;
            end else begin
                pipe_vld_q <= rd_en;
                if (rd_en) begin
                    pipe_data_q <= rd_word;
                end
            end
        end

        assign rd_vld_last  = pipe_vld_q;
        assign rd_data_last = pipe_data_q;
    end else begin : gen_lat1
        assign rd_vld_last  = rd_en;
        assign rd_data_last = rd_word;
    end

    // -------------------------------------------------------------------------
    // Output register: dout0 only moves when a read result arrives.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = rd_vld_last;
        if (rd_vld_last) begin
            dout_d = rd_data_last;
        end
    end

    always_ff @(posedge clk0 or negedge rst_aL) begin
        if (!rst_aL) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout0       = dout_q;
    assign dout_valid0 = dout_valid_q;

    // -------------------------------------------------------------------------
    // Sanity properties
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    // Read results only exist after the sweep, and ready0 never drops without reset.
    assert property (@(posedge clk0) disable iff (!rst_aL) dout_valid0 |-> ready0);
    assert property (@(posedge clk0) disable iff (!rst_aL) ready0 |=> ready0);
`endif

endmodule

// File: tb/tb_sram_1rw_param_init.sv
module tb_sram_1rw_param_init;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 6;
    localparam int unsigned NM = 16;

    logic          clk0   = 1'b0;
    logic          rst_aL = 1'b0;
    logic          csb0   = 1'b1;
    logic          web0   = 1'b1;
    logic [NM-1:0] wmask0 = '0;
    logic [AW-1:0] addr0  = '0;
    logic [DW-1:0] din0   = '0;

    logic [DW-1:0] dout_a, dout_b;
    logic          vld_a, vld_b, rdy_a, rdy_b;

    int total = 0;
    int bad   = 0;

    always #5 clk0 = ~clk0;

    // dut a: all defaults (READ_LATENCY = 1)
    sram_1rw_param_init u_dut_a (
        .clk0        (clk0),
        .rst_aL      (rst_aL),
        .csb0        (csb0),
        .web0        (web0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0        (din0),
        .dout0       (dout_a),
        .dout_valid0 (vld_a),
        .ready0      (rdy_a)
    );

    // dut b: READ_LATENCY = 2, same stimulus
    sram_1rw_param_init #(
        .READ_LATENCY (2)
    ) u_dut_b (
        .clk0        (clk0),
        .rst_aL      (rst_aL),
        .csb0        (csb0),
        .web0        (web0),
        .wmask0      (wmask0),
        .addr0       (addr0),
        .din0        (din0),
        .dout0       (dout_b),
        .dout_valid0 (vld_b),
        .ready0      (rdy_b)
    );

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NM-1:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        tick();
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a; wmask0 = '0;
        tick();
    endtask

    task automatic test_reset();
        rst_aL = 1'b0;
        idle();
        tick();
        tick();
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL reset_rdy_a: got %b want 0", rdy_a); end
        total++; if (rdy_b !== 1'b0) begin bad++; $display("FAIL reset_rdy_b: got %b want 0", rdy_b); end
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL reset_vld_a: got %b want 0", vld_a); end
        total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL reset_vld_b: got %b want 0", vld_b); end
        total++; if (dout_a !== '0) begin bad++; $display("FAIL reset_dout_a: got %h want 0", dout_a); end
        total++; if (dout_b !== '0) begin bad++; $display("FAIL reset_dout_b: got %h want 0", dout_b); end
    endtask

    // Sweep length, with a write to addr 7 held on the bus throughout INIT.
    task automatic test_init_sweep();
        int n;
        bit seen_vld;
        csb0 = 1'b0; web0 = 1'b0; addr0 = 7; din0 = {DW{1'b1}}; wmask0 = '1;
        rst_aL = 1'b1;
        n = 0;
        seen_vld = 1'b0;
        while (rdy_a !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (vld_a === 1'b1 || vld_b === 1'b1) seen_vld = 1'b1;
        end
        idle();
        total++; if (n != 64) begin bad++; $display("FAIL sweep_len: got %0d want 64", n); end
        total++; if (rdy_b !== 1'b1) begin bad++; $display("FAIL sweep_rdy_b: got %b want 1", rdy_b); end
        total++; if (seen_vld) begin bad++; $display("FAIL sweep_no_vld: got 1 want 0"); end
    endtask

    task automatic test_read_all();
        for (int a = 0; a < 64; a++) begin
            do_read(AW'(a));
            total++;
            if (vld_a !== 1'b1 || dout_a !== '0) begin
                bad++; $display("FAIL read_all_a[%0d]: got vld=%b dout=%h want vld=1 dout=0", a, vld_a, dout_a);
            end
            total++;
            if (vld_b !== (a > 0)) begin
                bad++; $display("FAIL read_all_vld_b[%0d]: got %b want %b", a, vld_b, (a > 0));
            end
        end
        idle();
        tick();
        total++; if (vld_b !== 1'b1 || dout_b !== '0) begin bad++; $display("FAIL read_all_b_last: got vld=%b dout=%h want vld=1 dout=0", vld_b, dout_b); end
        tick();
    endtask

    task automatic test_mask_write();
        logic [DW-1:0] exp;
        do_write(5, 128'hAABBCCDD, 16'h0003);
        idle();
        total++; if (vld_a !== 1'b0) begin bad++; $display("FAIL mask_wr_vld: got %b want 0", vld_a); end
        do_read(5);
        idle();
        total++; if (vld_a !== 1'b1) begin bad++; $display("FAIL mask_rd_vld_a: got %b want 1", vld_a); end
        total++; if (dout_a !== 128'h0000CCDD) begin bad++; $display("FAIL mask_rd_dout_a: got %h want 0000ccdd", dout_a); end
        total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL mask_rd_vld_b_early: got %b want 0", vld_b); end
        tick();
        total++; if (vld_a !== 1'b0 || dout_a !== 128'h0000CCDD) begin bad++; $display("FAIL mask_hold_a: got vld=%b dout=%h want vld=0 dout=0000ccdd", vld_a, dout_a); end
        total++; if (vld_b !== 1'b1 || dout_b !== 128'h0000CCDD) begin bad++; $display("FAIL mask_rd_b: got vld=%b dout=%h want vld=1 dout=0000ccdd", vld_b, dout_b); end
        tick();
        total++; if (vld_b !== 1'b0 || dout_b !== 128'h0000CCDD) begin bad++; $display("FAIL mask_hold_b: got vld=%b dout=%h want vld=0 dout=0000ccdd", vld_b, dout_b); end
        // wmask = 0 is a no-op, then only the top granule changes
        do_write(5, {DW{1'b1}}, 16'h0000);
        do_write(5, {8'h11, 120'h0}, 16'h8000);
        do_read(5);
        idle();
        exp = '0;
        exp[127:120] = 8'h11;
        exp[15:0] = 16'hCCDD;
        total++; if (dout_a !== exp) begin bad++; $display("FAIL mask_granule: got %h want %h", dout_a, exp); end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) do_write(AW'(i), DW'(i), '1);
        do_read(1);
        total++; if (vld_a !== 1'b1 || dout_a !== 128'd1) begin bad++; $display("FAIL b2b_a1: got vld=%b dout=%h want 1/1", vld_a, dout_a); end
        total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL b2b_b0: got %b want 0", vld_b); end
        do_read(2);
        total++; if (vld_a !== 1'b1 || dout_a !== 128'd2) begin bad++; $display("FAIL b2b_a2: got vld=%b dout=%h want 1/2", vld_a, dout_a); end
        total++; if (vld_b !== 1'b1 || dout_b !== 128'd1) begin bad++; $display("FAIL b2b_b1: got vld=%b dout=%h want 1/1", vld_b, dout_b); end
        do_read(3);
        idle();
        total++; if (vld_a !== 1'b1 || dout_a !== 128'd3) begin bad++; $display("FAIL b2b_a3: got vld=%b dout=%h want 1/3", vld_a, dout_a); end
        total++; if (vld_b !== 1'b1 || dout_b !== 128'd2) begin bad++; $display("FAIL b2b_b2: got vld=%b dout=%h want 1/2", vld_b, dout_b); end
        tick();
        total++; if (vld_a !== 1'b0 || dout_a !== 128'd3) begin bad++; $display("FAIL b2b_a_hold: got vld=%b dout=%h want 0/3", vld_a, dout_a); end
        total++; if (vld_b !== 1'b1 || dout_b !== 128'd3) begin bad++; $display("FAIL b2b_b3: got vld=%b dout=%h want 1/3", vld_b, dout_b); end
        tick();
        total++; if (vld_b !== 1'b0 || dout_b !== 128'd3) begin bad++; $display("FAIL b2b_b_hold: got vld=%b dout=%h want 0/3", vld_b, dout_b); end
        // read on the cycle right after a write to the same address
        do_write(9, 128'hDEADBEEF, '1);
        do_read(9);
        idle();
        total++; if (dout_a !== 128'hDEADBEEF) begin bad++; $display("FAIL raw_a: got %h want deadbeef", dout_a); end
        tick();
        total++; if (dout_b !== 128'hDEADBEEF) begin bad++; $display("FAIL raw_b: got %h want deadbeef", dout_b); end
        tick();
    endtask

    task automatic test_reset_mid_init();
        int n;
        bit seen_nz;
        #1 rst_aL = 1'b0;
        #1;
        total++; if (dout_a !== '0 || dout_b !== '0) begin bad++; $display("FAIL async_clr_dout: got a=%h b=%h want 0", dout_a, dout_b); end
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL async_clr_rdy: got %b want 0", rdy_a); end
        tick();
        rst_aL = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        total++; if (rdy_a !== 1'b0) begin bad++; $display("FAIL mid_init_rdy: got %b want 0", rdy_a); end
        #1 rst_aL = 1'b0;
        tick();
        tick();
        rst_aL = 1'b1;
        n = 0;
        seen_nz = 1'b0;
        while (rdy_a !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (dout_a !== '0 || dout_b !== '0) seen_nz = 1'b1;
        end
        total++; if (n != 64) begin bad++; $display("FAIL restart_len: got %0d want 64", n); end
        total++; if (seen_nz) begin bad++; $display("FAIL restart_dout_zero: got nonzero want 0"); end
    endtask

    task automatic test_reset_inflight();
        bit seen_vld;
        do_write(4, 128'h55, '1);
        do_read(4);
        idle();
        total++; if (vld_a !== 1'b1 || dout_a !== 128'h55) begin bad++; $display("FAIL inflight_pre_a: got vld=%b dout=%h want 1/55", vld_a, dout_a); end
        #1 rst_aL = 1'b0;
        #1;
        total++; if (vld_a !== 1'b0 || dout_a !== '0) begin bad++; $display("FAIL inflight_clr_a: got vld=%b dout=%h want 0/0", vld_a, dout_a); end
        total++; if (vld_b !== 1'b0 || dout_b !== '0) begin bad++; $display("FAIL inflight_clr_b: got vld=%b dout=%h want 0/0", vld_b, dout_b); end
        seen_vld = 1'b0;
        tick();
        if (vld_b === 1'b1) seen_vld = 1'b1;
        tick();
        if (vld_b === 1'b1) seen_vld = 1'b1;
        rst_aL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (vld_b === 1'b1 || vld_a === 1'b1) seen_vld = 1'b1;
        end
        total++; if (seen_vld) begin bad++; $display("FAIL inflight_no_pulse: got 1 want 0"); end
        total++; if (rdy_b !== 1'b0) begin bad++; $display("FAIL inflight_rdy: got %b want 0", rdy_b); end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_read_all();
        test_mask_write();
        test_back_to_back();
        test_reset_mid_init();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
